wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NR_FU, default 5, number of result sources (0 ALU, 1 branch, 2 LSU, 3 CSR, 4 MULT).
REQ-002 SHALL have parameter NR_WB_PORTS, default 2, number of scoreboard writeback ports.
REQ-003 SHALL have parameter DEPTH, default 2, entries per source buffer.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named clk_i and rst_i.
REQ-005 clk_i  input  1  clock; all state updates on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 flush_i  input  1  discard all buffered results.
REQ-008 fu_valid_i  input  NR_FU  per-source result valid, single-cycle pulse, no backpressure.
REQ-009 fu_trans_id_i  input  NR_FU x TRANS_ID_BITS  scoreboard entry per source.
REQ-010 fu_result_i  input  NR_FU x 64  result data per source.
REQ-011 fu_exception_i  input  NR_FU x exception_t  exception per source.
REQ-012 fu_full_o  output  NR_FU  source buffer holds DEPTH entries; issue stops dispatching to that FU.
REQ-013 wb_valid_o  output  NR_WB_PORTS  writeback port valid.
REQ-014 wb_trans_id_o, wb_result_o, wb_exception_o  output  NR_WB_PORTS x (TRANS_ID_BITS / 64 / exception_t)  writeback payload.
REQ-015 wb_ready_i  input  1  scoreboard accepts every valid port this cycle.
REQ-016 overflow_o  output  1  sticky error: a push was dropped.

Function
REQ-017 Each source SHALL own a DEPTH-entry FIFO storing {trans_id, result, exception}; fu_valid_i pushes at the clock edge.
REQ-018 Latency SHALL be one cycle minimum: entry pushed at edge N is eligible at wb outputs in cycle N+1; no input-to-output bypass.
REQ-019 Order within one source SHALL be preserved; no ordering guarantee across sources.
REQ-020 Each cycle the arbiter SHALL scan non-empty FIFOs from rr_ptr upward (mod NR_FU) and grant up to NR_WB_PORTS FIFO heads, at most one per source.
REQ-021 Grants SHALL fill port 0 first; port k valid only if all ports < k are valid.
REQ-022 wb_* outputs SHALL be combinational from FIFO heads and rr_ptr.
REQ-023 On wb_ready_i=1, every granted FIFO SHALL pop and rr_ptr SHALL advance to (index of last granted source + 1) mod NR_FU; with no grant rr_ptr holds.
REQ-024 On wb_ready_i=0, no pop, rr_ptr holds, and wb outputs SHALL remain stable unless a previously empty FIFO gains an entry.
REQ-025 fu_full_o[i] SHALL equal (count[i]==DEPTH), registered-state based.
REQ-026 Push and pop on the same FIFO in the same cycle SHALL both take effect, including when full (count unchanged).
REQ-027 Push to a full FIFO without a same-cycle pop SHALL drop the new entry, leave the FIFO unchanged and set overflow_o.
REQ-028 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-029 flush_i SHALL empty all FIFOs, set rr_ptr=0, and discard same-cycle pushes; wb_valid_o SHALL be 0 during the flush cycle; overflow_o SHALL be unaffected.

Reset
REQ-030 rst_i SHALL empty all FIFOs, set rr_ptr=0, clear overflow_o; rst_i has priority over flush_i and pushes.
REQ-031 Reset values: wb_valid_o=0, fu_full_o=0, overflow_o=0; wb payload outputs driven 0 while invalid.
REQ-032 Reset asserted mid-operation SHALL drop all buffered entries without any writeback in that cycle.

Structure
REQ-033 NR_WB_PORTS and a FU index enum (ALU, BRANCH, LSU, CSR, MULT) SHALL reside in ariane_pkg; exception_t and TRANS_ID_BITS are reused from ariane_pkg.
REQ-034 Per-source buffering SHALL be one sub-module, wb_fifo (parameter DEPTH, push/pop/full/empty/flush), instantiated NR_FU times; arbitration lives in wb_arbiter.

Verification
REQ-035 ALU valid trans_id=3 result=0xAA at cycle 0, wb_ready_i=1 -> port0 valid cycle 1 with id 3, 0xAA; port1 invalid.
REQ-036 ALU, LSU, MULT valid same cycle (ids 1,2,4), rr_ptr=0 -> cycle 1: port0=ALU id1, port1=LSU id2, rr_ptr=3; cycle 2: port0=MULT id4.
REQ-037 wb_ready_i=0 while CSR pushes ids 5,6 -> fu_full_o[3]=1, outputs hold id5; third push -> dropped, overflow_o=1; ready=1 -> ids 5,6 drain in order.
REQ-038 CSR full plus push and ready=1 same cycle -> count stays 2, no overflow, next head id6.
REQ-039 Three buffered entries, flush_i=1 with ALU push -> next cycle all FIFOs empty, wb_valid_o=0, rr_ptr=0.
REQ-040 rst_i=1 with entries buffered and overflow_o=1 -> next cycle all outputs 0, overflow_o=0.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core types reused by the writeback arbiter.
// Holds trans-id width, exception layout and FU indices.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned NR_WB_PORTS = 2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    BRANCH = 3'd1,
    LSU    = 3'd2,
    CSR    = 3'd3,
    MULT   = 3'd4
  } fu_idx_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    exception_t               ex;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Result-source and writeback bus between FUs, arbiter and scoreboard.
// master is the arbiter side, slave the FU/scoreboard side.
interface wb_arbiter_if
  import ariane_pkg::*;
#(
  parameter int unsigned NR_FU       = 5,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS
);

  logic                                         flush_i;
  logic [NR_FU-1:0]                             fu_valid_i;
  logic [NR_FU-1:0][TRANS_ID_BITS-1:0]          fu_trans_id_i;
  logic [NR_FU-1:0][63:0]                       fu_result_i;
  exception_t [NR_FU-1:0]                       fu_exception_i;
  logic [NR_FU-1:0]                             fu_full_o;

  logic [NR_WB_PORTS-1:0]                       wb_valid_o;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_o;
  logic [NR_WB_PORTS-1:0][63:0]                 wb_result_o;
  exception_t [NR_WB_PORTS-1:0]                 wb_exception_o;
  logic                                         wb_ready_i;
  logic                                         overflow_o;

  modport master (
    input  flush_i,
    input  fu_valid_i,
    input  fu_trans_id_i,
    input  fu_result_i,
    input  fu_exception_i,
    output fu_full_o,
    output wb_valid_o,
    output wb_trans_id_o,
    output wb_result_o,
    output wb_exception_o,
    input  wb_ready_i,
    output overflow_o
  );

  modport slave (
    output flush_i,
    output fu_valid_i,
    output fu_trans_id_i,
    output fu_result_i,
    output fu_exception_i,
    input  fu_full_o,
    input  wb_valid_o,
    input  wb_trans_id_o,
    input  wb_result_o,
    input  wb_exception_o,
    output wb_ready_i,
    input  overflow_o
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-source result buffer; a push into a full FIFO survives only
// when the head leaves in the same cycle, otherwise it is dropped.
module wb_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  wb_entry_t data_i,
  input  logic      pop_i,
  output wb_entry_t data_o,
  output logic      full_o,
  output logic      empty_o,
  output logic      drop_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   rd_q;
  logic [PW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop && !flush_i;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      // when full, wr_q == rd_q: the head is read out before it is overwritten
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= inc(rd_q);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: buffers FU results and grants up
// to NR_WB_PORTS FIFO heads per cycle, at most one per source.
module wb_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_FU       = 5,
  parameter int unsigned NR_WB_PORTS = ariane_pkg::NR_WB_PORTS,
  parameter int unsigned DEPTH       = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  wb_arbiter_if.master bus
);

  localparam int unsigned FW = (NR_FU > 1) ? $clog2(NR_FU) : 1;

  wb_entry_t [NR_FU-1:0]  din;
  wb_entry_t [NR_FU-1:0]  head;
  logic [NR_FU-1:0]       full;
  logic [NR_FU-1:0]       empty;
  logic [NR_FU-1:0]       drop;
  logic [NR_FU-1:0]       gnt;
  logic [NR_FU-1:0]       pop;

  logic [FW-1:0]          rr_q;
  logic [FW-1:0]          rr_d;
  logic                   ovf_q;
  logic                   allow;

  logic [NR_WB_PORTS-1:0]                    wb_valid;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_id;
  logic [NR_WB_PORTS-1:0][63:0]              wb_res;
  exception_t [NR_WB_PORTS-1:0]              wb_ex;

  for (genvar i = 0; i < NR_FU; i++) begin : g_fifo
    assign din[i] = '{
      trans_id: bus.fu_trans_id_i[i],
      result:   bus.fu_result_i[i],
      ex:       bus.fu_exception_i[i]
    };

    wb_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(bus.flush_i),
      .push_i (bus.fu_valid_i[i]),
      .data_i (din[i]),
      .pop_i  (pop[i]),
      .data_o (head[i]),
      .full_o (full[i]),
      .empty_o(empty[i]),
      .drop_o (drop[i])
    );
  end

  // nothing is written back while state is being cleared
  assign allow = !rst_i && !bus.flush_i;

  always_comb begin
    logic [NR_WB_PORTS-1:0] slot;
    logic [FW-1:0]          idx;
    gnt      = '0;
    slot     = NR_WB_PORTS'(1);
    idx      = '0;
    rr_d     = rr_q;
    wb_valid = '0;
    wb_id    = '0;
    wb_res   = '0;
    wb_ex    = '0;
    for (int k = 0; k < NR_FU; k++) begin
      if (rr_q >= FW'(NR_FU - k)) begin
        idx = rr_q - FW'(NR_FU - k);
      end else begin
        idx = rr_q + FW'(k);
      end
      if (allow && !empty[idx] && slot != '0) begin
        gnt[idx] = 1'b1;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
          if (slot[p]) begin
            wb_valid[p] = 1'b1;
            wb_id[p]    = head[idx].trans_id;
            wb_res[p]   = head[idx].result;
            wb_ex[p]    = head[idx].ex;
          end
        end
        slot = slot << 1;
        rr_d = (idx == FW'(NR_FU - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  assign pop = gnt & {NR_FU{bus.wb_ready_i}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|drop);
      if (bus.flush_i) begin
        rr_q <= '0;
      end else if (bus.wb_ready_i) begin
        rr_q <= rr_d;
      end
    end
  end

  assign bus.fu_full_o      = full;
  assign bus.overflow_o     = ovf_q;
  assign bus.wb_valid_o     = wb_valid;
  assign bus.wb_trans_id_o  = wb_id;
  assign bus.wb_result_o    = wb_res;
  assign bus.wb_exception_o = wb_ex;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin order,
// full/overflow, flush and reset behaviour.
module tb_wb_arbiter;
  import ariane_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_arbiter_if #(.NR_FU(5), .NR_WB_PORTS(2)) bus ();

  wb_arbiter #(
    .NR_FU      (5),
    .NR_WB_PORTS(2),
    .DEPTH      (2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] fu, input logic [2:0] id,
                      input logic [63:0] res);
    bus.fu_valid_i[fu]    = 1'b1;
    bus.fu_trans_id_i[fu] = id;
    bus.fu_result_i[fu]   = res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.fu_valid_i     = '0;
    bus.fu_exception_i = '0;
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    bus.flush_i        = 1'b0;
    bus.wb_ready_i     = 1'b1;
    bus.fu_valid_i     = '0;
    bus.fu_trans_id_i  = '0;
    bus.fu_result_i    = '0;
    bus.fu_exception_i = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 128'(bus.wb_valid_o), 0);
    chk("rst_full", 128'(bus.fu_full_o), 0);
    chk("rst_ovf", 128'(bus.overflow_o), 0);
    chk("rst_id", 128'(bus.wb_trans_id_o), 0);
    chk("rst_res", bus.wb_result_o, 0);

    // single ALU result, one-cycle latency
    push(3'd0, 3'd3, 64'hAA);
    bus.fu_exception_i[0].valid = 1'b1;
    bus.fu_exception_i[0].cause = 64'd5;
    #1;
    chk("nobypass_v", 128'(bus.wb_valid_o), 0);
    tick();
    chk("alu_v", 128'(bus.wb_valid_o), 128'b01);
    chk("alu_id", 128'(bus.wb_trans_id_o[0]), 3);
    chk("alu_res", 128'(bus.wb_result_o[0]), 128'hAA);
    chk("alu_ex", 128'(bus.wb_exception_o[0].cause), 5);
    chk("alu_exv", 128'(bus.wb_exception_o[0].valid), 1);
    chk("alu_p1_id", 128'(bus.wb_trans_id_o[1]), 0);
    tick();
    chk("alu_drained", 128'(bus.wb_valid_o), 0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;

    // three sources at once, rr_ptr starts at 0
    push(3'd0, 3'd1, 64'h11);
    push(3'd2, 3'd2, 64'h22);
    push(3'd4, 3'd4, 64'h44);
    tick();
    chk("rr1_v", 128'(bus.wb_valid_o), 128'b11);
    chk("rr1_id0", 128'(bus.wb_trans_id_o[0]), 1);
    chk("rr1_id1", 128'(bus.wb_trans_id_o[1]), 2);
    chk("rr1_res1", 128'(bus.wb_result_o[1]), 128'h22);
    push(3'd0, 3'd7, 64'h77);
    tick();
    chk("rr2_v", 128'(bus.wb_valid_o), 128'b11);
    chk("rr2_id0", 128'(bus.wb_trans_id_o[0]), 4);
    chk("rr2_id1", 128'(bus.wb_trans_id_o[1]), 7);
    tick();
    chk("rr3_v", 128'(bus.wb_valid_o), 0);

    // CSR fill, push-with-pop when full, overflow
    bus.wb_ready_i = 1'b0;
    push(3'd3, 3'd5, 64'h55);
    tick();
    chk("csr1_v", 128'(bus.wb_valid_o), 128'b01);
    chk("csr1_id", 128'(bus.wb_trans_id_o[0]), 5);
    chk("csr1_full", 128'(bus.fu_full_o), 0);
    push(3'd3, 3'd6, 64'h66);
    tick();
    chk("csr2_full", 128'(bus.fu_full_o), 128'b01000);
    chk("csr2_hold", 128'(bus.wb_trans_id_o[0]), 5);
    chk("csr2_ovf", 128'(bus.overflow_o), 0);
    bus.wb_ready_i = 1'b1;
    push(3'd3, 3'd0, 64'h88);
    chk("csr3_pre", 128'(bus.wb_trans_id_o[0]), 5);
    tick();
    bus.wb_ready_i = 1'b0;
    chk("csr3_full", 128'(bus.fu_full_o), 128'b01000);
    chk("csr3_ovf", 128'(bus.overflow_o), 0);
    chk("csr3_id", 128'(bus.wb_trans_id_o[0]), 6);
    push(3'd3, 3'd2, 64'h99);
    tick();
    chk("csr4_ovf", 128'(bus.overflow_o), 1);
    chk("csr4_full", 128'(bus.fu_full_o), 128'b01000);
    chk("csr4_id", 128'(bus.wb_trans_id_o[0]), 6);
    bus.wb_ready_i = 1'b1;
    tick();
    chk("csr5_id", 128'(bus.wb_trans_id_o[0]), 0);
    chk("csr5_res", 128'(bus.wb_result_o[0]), 128'h88);
    chk("csr5_full", 128'(bus.fu_full_o), 0);
    tick();
    chk("csr6_v", 128'(bus.wb_valid_o), 0);

    // flush with buffered entries and a same-cycle push
    bus.wb_ready_i = 1'b0;
    push(3'd0, 3'd1, 64'h1);
    push(3'd1, 3'd2, 64'h2);
    push(3'd2, 3'd3, 64'h3);
    tick();
    chk("fl_pre_v", 128'(bus.wb_valid_o), 128'b11);
    chk("fl_pre_id0", 128'(bus.wb_trans_id_o[0]), 1);
    chk("fl_pre_id1", 128'(bus.wb_trans_id_o[1]), 2);
    bus.flush_i = 1'b1;
    push(3'd0, 3'd5, 64'h5);
    #1;
    chk("fl_cyc_v", 128'(bus.wb_valid_o), 0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("fl_v", 128'(bus.wb_valid_o), 0);
    chk("fl_full", 128'(bus.fu_full_o), 0);
    chk("fl_ovf", 128'(bus.overflow_o), 1);
    bus.wb_ready_i = 1'b1;
    push(3'd1, 3'd6, 64'h6);
    push(3'd4, 3'd7, 64'h7);
    tick();
    chk("fl_rr_id0", 128'(bus.wb_trans_id_o[0]), 6);
    chk("fl_rr_id1", 128'(bus.wb_trans_id_o[1]), 7);
    tick();
    chk("fl_rr_v", 128'(bus.wb_valid_o), 0);

    // reset mid-operation
    bus.wb_ready_i = 1'b0;
    push(3'd0, 3'd1, 64'h1);
    push(3'd3, 3'd2, 64'h2);
    tick();
    push(3'd0, 3'd3, 64'h3);
    tick();
    chk("mr_full", 128'(bus.fu_full_o), 128'b00001);
    rst = 1'b1;
    #1;
    chk("mr_cyc_v", 128'(bus.wb_valid_o), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_v", 128'(bus.wb_valid_o), 0);
    chk("mr_full0", 128'(bus.fu_full_o), 0);
    chk("mr_ovf", 128'(bus.overflow_o), 0);
    chk("mr_id", 128'(bus.wb_trans_id_o), 0);
    chk("mr_res", bus.wb_result_o, 0);
    bus.wb_ready_i = 1'b1;
    push(3'd2, 3'd5, 64'h99);
    tick();
    chk("post_v", 128'(bus.wb_valid_o), 128'b01);
    chk("post_id", 128'(bus.wb_trans_id_o[0]), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
